// File: rtl/issue_pkg.sv
// Shared definitions for the issue dispatcher: execution unit indices,
// default sizing and the one-hot legality check used on decode selects.
package issue_pkg;

    // Bit positions of the execution units in a select/valid vector.
    typedef enum int unsigned {
        UNIT_INT = 0,
        UNIT_VEC = 1,
        UNIT_LSU = 2
    } unit_idx_e;

    localparam int DEF_NUM_UNITS = 3;
    localparam int DEF_UOP_WIDTH = 4;
    localparam int DEF_DEPTH     = 4;

    // Widest select vector the one-hot check handles; narrower selects are
    // zero-extended by the caller.
    localparam int SEL_MAX_W = 32;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - SEL_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Issue buffer storage: in-order FIFO with push/pop/flush and an entry count.
// DEPTH must be a power of two so the pointers wrap naturally.
module issue_fifo
    import issue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Ignore pushes when full and pops when empty so the count stays in range.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointer/count values; flush returns everything to the empty state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since the count guards reads.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/issue_dispatch.sv
// In-order issue dispatcher: buffers decoded micro-ops and issues the head
// entry to its one-hot selected execution unit. Non-one-hot selects are
// consumed and flagged with a one-cycle illegal_sel_out pulse.
// Optional build macro ISSUE_BYPASS_EN: when the buffer is empty and the
// target unit is ready, a legal micro-op issues in the same cycle.
module issue_dispatch
    import issue_pkg::*;
#(
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int UOP_WIDTH = DEF_UOP_WIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                           clock_in,
    input  logic                           reset_in,
    input  logic                           flush_in,
    input  logic                           dec_valid_in,
    output logic                           dec_ready_out,
    input  logic [NUM_UNITS-1:0]           exec_unit_sel_in,
    input  logic [UOP_WIDTH-1:0]           exec_uop_in,
    output logic [NUM_UNITS-1:0]           unit_valid_out,
    input  logic [NUM_UNITS-1:0]           unit_ready_in,
    output logic [NUM_UNITS*UOP_WIDTH-1:0] unit_uop_out,
    output logic                           illegal_sel_out,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy_out
);

    localparam int EW = NUM_UNITS + UOP_WIDTH;
    localparam int CW = $clog2(DEPTH + 1);

    logic [EW-1:0]        fifo_rdata;
    logic [NUM_UNITS-1:0] head_sel;
    logic [UOP_WIDTH-1:0] head_uop;
    logic [UOP_WIDTH-1:0] issue_uop;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty, fifo_full;
    logic                 accept, legal, head_valid, fire, push, pop;
    logic                 illegal_q, illegal_d;

    assign {head_sel, head_uop} = fifo_rdata;

    // No pop credit when full: readiness depends only on stored occupancy.
    assign dec_ready_out = ~fifo_full & ~flush_in & ~reset_in;
    assign accept        = dec_valid_in & dec_ready_out;
    assign legal         = is_onehot(SEL_MAX_W'(exec_unit_sel_in));
    assign head_valid    = ~fifo_empty & ~flush_in & ~reset_in;
    assign fire          = |(unit_valid_out & unit_ready_in);
    assign pop           = head_valid & fire;

`ifdef ISSUE_BYPASS_EN
    logic byp_valid;
    // accept already excludes flush and reset.
    assign byp_valid = accept & legal & fifo_empty;
    // A bypassed micro-op that issues immediately is never stored.
    assign push      = accept & legal & ~(byp_valid & fire);
`else
    assign push      = accept & legal;
`endif

    // Per-unit valid and micro-op slices; unselected slices stay zero.
    always_comb begin
        unit_valid_out = '0;
        unit_uop_out   = '0;
        issue_uop      = head_uop;
        if (head_valid) begin
            unit_valid_out = head_sel;
        end
`ifdef ISSUE_BYPASS_EN
        else if (byp_valid) begin
            unit_valid_out = exec_unit_sel_in;
            issue_uop      = exec_uop_in;
        end
`endif
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (unit_valid_out[i]) begin
                unit_uop_out[i*UOP_WIDTH +: UOP_WIDTH] = issue_uop;
            end
        end
    end

    assign illegal_d       = accept & ~legal;
    assign illegal_sel_out = illegal_q;
    assign occupancy_out   = fifo_count;

    // Illegal-select pulse register; flush does not suppress a pending pulse.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    issue_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clock_in),
        .rst_i       (reset_in),
        .flush_i     (flush_in),
        .push_i      (push),
        .push_data_i ({exec_unit_sel_in, exec_uop_in}),
        .pop_i       (pop),
        .pop_data_o  (fifo_rdata),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

endmodule

// File: tb/tb_issue_dispatch.sv
// Directed bench for issue_dispatch (default parameters). Expected issues are
// queued when stimulus is driven and compared whenever a unit handshake occurs.
// Honors ISSUE_BYPASS_EN so the same bench covers either build.
module tb_issue_dispatch;
    import issue_pkg::*;

`ifdef ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, dv;
    logic [2:0]  sel;
    logic [3:0]  uop;
    logic [2:0]  ready;
    logic        dready;
    logic [2:0]  uvalid;
    logic [11:0] uuop;
    logic        illegal;
    logic [2:0]  occ;

    typedef struct {
        int unsigned unit;
        logic [3:0]  uop;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    issue_dispatch #(
        .NUM_UNITS (3),
        .UOP_WIDTH (4),
        .DEPTH     (4)
    ) dut (
        .clock_in         (clk),
        .reset_in         (rst),
        .flush_in         (flush),
        .dec_valid_in     (dv),
        .dec_ready_out    (dready),
        .exec_unit_sel_in (sel),
        .exec_uop_in      (uop),
        .unit_valid_out   (uvalid),
        .unit_ready_in    (ready),
        .unit_uop_out     (uuop),
        .illegal_sel_out  (illegal),
        .occupancy_out    (occ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] u);
        dv  = v;
        sel = s;
        uop = u;
    endtask

    task automatic expect_issue(input int unsigned unit, input logic [3:0] u);
        exp_t e;
        e.unit = unit;
        e.uop  = u;
        sbq.push_back(e);
    endtask

    // Move to 1 time unit before the rising edge and score any handshakes.
    task automatic sample();
        exp_t e;
        #4;
        chk("valid_at_most_one", 32'($countones(uvalid) <= 1), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (uvalid[i] && ready[i]) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_issue", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_unit", 32'(i), 32'(e.unit));
                    chk("sb_uop", 32'(uuop[i*4 +: 4]), 32'(e.uop));
                end
            end else if (!uvalid[i]) begin
                chk("idle_slice_zero", 32'(uuop[i*4 +: 4]), 32'd0);
            end
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ready = 3'b000;
        drive(1'b0, 3'b000, 4'h0);
        adv(); adv();
        sample();
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_valid", 32'(uvalid), 32'd0);
        chk("rst_uop", 32'(uuop), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        adv();
        rst = 1'b0;
        sample();
        chk("post_rst_ready", 32'(dready), 32'd1);
        chk("post_rst_occ", 32'(occ), 32'd0);
        adv();

        // Single int micro-op, all units ready.
        ready = 3'b111;
        drive(1'b1, 3'b001, 4'h5); expect_issue(UNIT_INT, 4'h5);
        sample();
        chk("t1_first_cycle_valid", 32'(uvalid), BYP ? 32'h1 : 32'h0);
        adv();
        drive(1'b0, 3'b000, 4'h0);
        sample();
        chk("t1_next_cycle_valid", 32'(uvalid), BYP ? 32'h0 : 32'h1);
        adv();
        sample();
        chk("t1_occ", 32'(occ), 32'd0);
        adv();

        // Fill with four lsu entries, lsu not ready, then drain in order.
        ready = 3'b000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 3'b100, 4'(k + 1)); expect_issue(UNIT_LSU, 4'(k + 1));
            sample();
            adv();
        end
        drive(1'b1, 3'b100, 4'hF);
        sample();
        chk("t2_full_occ", 32'(occ), 32'd4);
        chk("t2_full_ready", 32'(dready), 32'd0);
        chk("t2_full_valid", 32'(uvalid), 32'h4);
        adv();
        drive(1'b0, 3'b000, 4'h0);
        ready = 3'b100;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("t2_drain_valid", 32'(uvalid), 32'h4);
            adv();
        end
        sample();
        chk("t2_drained_occ", 32'(occ), 32'd0);
        chk("t2_drained_valid", 32'(uvalid), 32'd0);
        adv();

        // Head blocked by unready vec unit stalls younger int entry.
        ready = 3'b101;
        drive(1'b1, 3'b010, 4'h6); expect_issue(UNIT_VEC, 4'h6);
        sample(); adv();
        drive(1'b1, 3'b001, 4'h7); expect_issue(UNIT_INT, 4'h7);
        sample(); adv();
        drive(1'b0, 3'b000, 4'h0);
        sample();
        chk("t3_blocked_valid", 32'(uvalid), 32'h2);
        chk("t3_blocked_occ", 32'(occ), 32'd2);
        adv();
        sample();
        chk("t3_still_blocked", 32'(uvalid), 32'h2);
        adv();
        ready = 3'b111;
        sample(); adv();
        sample(); adv();
        sample();
        chk("t3_occ", 32'(occ), 32'd0);
        adv();

        // Back-to-back accept and issue keeps occupancy constant.
        ready = 3'b111;
        drive(1'b1, 3'b001, 4'h8); expect_issue(UNIT_INT, 4'h8);
        sample(); adv();
        drive(1'b1, 3'b010, 4'h9); expect_issue(UNIT_VEC, 4'h9);
        sample(); adv();
        drive(1'b1, 3'b100, 4'hA); expect_issue(UNIT_LSU, 4'hA);
        sample();
        chk("t4_steady_occ", 32'(occ), BYP ? 32'd0 : 32'd1);
        adv();
        drive(1'b0, 3'b000, 4'h0);
        sample(); adv();
        sample();
        chk("t4_occ", 32'(occ), 32'd0);
        adv();

        // Illegal selects: multi-bit then zero.
        drive(1'b1, 3'b011, 4'h9);
        sample();
        chk("t5_multi_accepted", 32'(dready), 32'd1);
        chk("t5_multi_no_pulse_yet", 32'(illegal), 32'd0);
        adv();
        drive(1'b0, 3'b000, 4'h0);
        sample();
        chk("t5_multi_pulse", 32'(illegal), 32'd1);
        chk("t5_multi_no_valid", 32'(uvalid), 32'd0);
        chk("t5_multi_occ", 32'(occ), 32'd0);
        adv();
        sample();
        chk("t5_multi_pulse_end", 32'(illegal), 32'd0);
        adv();
        drive(1'b1, 3'b000, 4'h3);
        sample();
        chk("t5_zero_accepted", 32'(dready), 32'd1);
        adv();
        drive(1'b0, 3'b000, 4'h0);
        sample();
        chk("t5_zero_pulse", 32'(illegal), 32'd1);
        chk("t5_zero_no_valid", 32'(uvalid), 32'd0);
        chk("t5_zero_occ", 32'(occ), 32'd0);
        adv();
        sample();
        chk("t5_zero_pulse_end", 32'(illegal), 32'd0);
        adv();

        // Flush with three buffered entries and a pending illegal pulse.
        ready = 3'b000;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'b001, 4'(k + 1));
            sample(); adv();
        end
        drive(1'b1, 3'b110, 4'h4);
        sample();
        chk("t6_pre_flush_occ", 32'(occ), 32'd3);
        chk("t6_illegal_accepted", 32'(dready), 32'd1);
        adv();
        flush = 1'b1;
        ready = 3'b111;
        drive(1'b1, 3'b001, 4'h5);
        sample();
        chk("t6_flush_ready", 32'(dready), 32'd0);
        chk("t6_flush_valid", 32'(uvalid), 32'd0);
        chk("t6_flush_pulse", 32'(illegal), 32'd1);
        adv();
        flush = 1'b0;
        drive(1'b0, 3'b000, 4'h0);
        sample();
        chk("t6_flushed_occ", 32'(occ), 32'd0);
        chk("t6_flushed_valid", 32'(uvalid), 32'd0);
        chk("t6_pulse_end", 32'(illegal), 32'd0);
        adv();
        drive(1'b1, 3'b100, 4'hC); expect_issue(UNIT_LSU, 4'hC);
        sample(); adv();
        drive(1'b0, 3'b000, 4'h0);
        sample();
        chk("t6_refill_valid", 32'(uvalid), BYP ? 32'h0 : 32'h4);
        adv();
        sample();
        chk("t6_refill_occ", 32'(occ), 32'd0);
        adv();

        // Reset mid-operation discards entries without issuing.
        ready = 3'b000;
        drive(1'b1, 3'b001, 4'h1); sample(); adv();
        drive(1'b1, 3'b010, 4'h2); sample(); adv();
        rst = 1'b1;
        ready = 3'b111;
        drive(1'b1, 3'b001, 4'h3);
        sample();
        chk("t7_rst_valid", 32'(uvalid), 32'd0);
        chk("t7_rst_uop", 32'(uuop), 32'd0);
        adv();
        rst = 1'b0;
        drive(1'b0, 3'b000, 4'h0);
        sample();
        chk("t7_occ", 32'(occ), 32'd0);
        chk("t7_valid", 32'(uvalid), 32'd0);
        chk("t7_ready", 32'(dready), 32'd1);
        adv();

        // Empty buffer, vec ready: same-cycle issue only with bypass.
        ready = 3'b010;
        drive(1'b1, 3'b010, 4'hA); expect_issue(UNIT_VEC, 4'hA);
        sample();
        chk("t8_same_valid", 32'(uvalid), BYP ? 32'h2 : 32'h0);
        chk("t8_same_uop", 32'(uuop), BYP ? 32'h0A0 : 32'h000);
        adv();
        drive(1'b0, 3'b000, 4'h0);
        sample();
        chk("t8_next_valid", 32'(uvalid), BYP ? 32'h0 : 32'h2);
        chk("t8_next_occ", 32'(occ), BYP ? 32'd0 : 32'd1);
        adv();
        sample();
        chk("t8_occ", 32'(occ), 32'd0);
        adv();

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_dispatch.md
ISSUE_DISPATCH -- requirements
Module: issue_dispatch

Interface
REQ-001 Parameter NUM_UNITS, default 3: number of execution units; bit 0 int, bit 1 vec, bit 2 lsu, higher bits reserved for future units.
REQ-002 Parameter UOP_WIDTH, default 4: micro-op width.
REQ-003 Parameter DEPTH, default 4: issue buffer entries; power of two, >= 2.
REQ-004 clock_in  input  1  single clock; all state updates on rising edge.
REQ-005 reset_in  input  1  synchronous, active-high reset.
REQ-006 flush_in  input  1  discard all buffered micro-ops.
REQ-007 dec_valid_in  input  1  decode offers a micro-op.
REQ-008 dec_ready_out  output  1  dispatcher can accept this cycle.
REQ-009 exec_unit_sel_in  input  NUM_UNITS  one-hot target unit.
REQ-010 exec_uop_in  input  UOP_WIDTH  micro-op.
REQ-011 unit_valid_out  output  NUM_UNITS  per-unit issue valid, at most one bit set.
REQ-012 unit_ready_in  input  NUM_UNITS  per-unit ready.
REQ-013 unit_uop_out  output  NUM_UNITS*UOP_WIDTH  per-unit micro-op, slice i for unit i.
REQ-014 illegal_sel_out  output  1  one-cycle pulse: non-one-hot select was accepted.
REQ-015 occupancy_out  output  $clog2(DEPTH+1)  current buffered entry count.

Function
REQ-016 Accept = dec_valid_in & dec_ready_out; dec_ready_out = (occupancy < DEPTH) & !flush_in, no same-cycle pop credit when full.
REQ-017 Legal accepted entry {sel, uop} written at tail; issue strictly in order from head only.
REQ-018 unit_valid_out[i] = buffer non-empty & head sel[i] & !flush_in; entry issued when unit_ready_in[i] also high.
REQ-019 Non-selected unit_uop_out slices drive all-zero; selected slice drives head uop while valid, zero otherwise.
REQ-020 Non-one-hot select (zero or multiple bits) on accept: handshake completes, entry not written, illegal_sel_out high next cycle for exactly one cycle.
REQ-021 Latency: legal entry accepted in cycle N appears on unit_valid_out in cycle N+1 at earliest (bypass off).
REQ-022 Head blocked by unready unit stalls all younger entries (no reordering).
REQ-023 Simultaneous accept and issue: occupancy unchanged, pointers both advance.
REQ-024 Pointers wrap modulo DEPTH; occupancy saturates at DEPTH by REQ-016, never underflows.
REQ-025 flush_in: next cycle occupancy 0, pointers 0; flush wins over same-cycle accept and issue; pending illegal_sel_out pulse still emitted.

Reset
REQ-026 reset_in high: occupancy_out 0, pointers 0, unit_valid_out 0, unit_uop_out 0, illegal_sel_out 0; dec_ready_out 1 the cycle after reset release.
REQ-027 Reset mid-operation discards all entries without issuing; reset takes priority over flush, accept and issue.

Configuration
REQ-028 Macro ISSUE_BYPASS_EN defined: buffer empty, legal select, target unit ready, no flush -> micro-op issued combinationally same cycle, not written to buffer.
REQ-029 Macro ISSUE_BYPASS_EN undefined: every legal entry passes through the buffer per REQ-021; no combinational path from dec_* to unit_*.

Structure
REQ-030 Shared package issue_pkg holds unit index constants (INT 0, VEC 1, LSU 2), default NUM_UNITS/UOP_WIDTH/DEPTH, one-hot check function.
REQ-031 Storage in sub-module issue_fifo (parametrised width/depth, push/pop/flush, count); issue_dispatch holds select decode, legality check, output gating.

Verification
REQ-032 Reset, then sel 3'b001 uop 4'h5, all units ready -> next cycle unit_valid_out 3'b001, int slice 4'h5, others 0; occupancy returns 0.
REQ-033 Push 4 entries sel 3'b100 with unit_ready_in 0 -> occupancy 4, dec_ready_out 0; raise lsu ready -> 4 issues in 4 cycles, push order preserved.
REQ-034 sel 3'b011 accepted -> no unit_valid, occupancy unchanged, illegal_sel_out high exactly one cycle; repeat with sel 3'b000.
REQ-035 3 entries buffered, flush_in with same-cycle dec_valid_in -> nothing accepted, unit_valid_out 0 that cycle, occupancy 0 next cycle.
REQ-036 ISSUE_BYPASS_EN build, empty buffer, sel 3'b010 uop 4'hA, vec ready -> vec valid and 4'hA same cycle, occupancy stays 0; non-bypass build -> issue one cycle later.
